// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the sequential radix-4 Booth multiplier.
package mult_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned STEPS = 16;
    localparam int unsigned CNT_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_booth_seq_step_counter.sv
// Booth step counter: counts RUN cycles and flags the last one.
module step_counter
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_wrap_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_wrap_c = i_en && (r_count == CNT_W'(STEPS - 1));

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential signed 32x32 multiplier, one radix-4 Booth step per clock over 16 cycles.
module mult_booth_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned ACC_W = WIDTH + 2;
    localparam int unsigned SH_W  = ACC_W + WIDTH + 1;

    state_t r_state;
    state_t w_state_nxt;

    logic [ACC_W-1:0]        r_acc;
    logic [WIDTH-1:0]        r_mult;
    logic                    r_guard;
    logic [WIDTH-1:0]        r_mcand;
    logic [WIDTH-1:0]        r_result;
    logic                    r_exc;
    logic                    r_rdy;
    logic                    r_busy;

    logic                    w_step;
    logic                    w_wrap;
    logic [ACC_W-1:0]        w_m;
    logic [ACC_W-1:0]        w_m2;
    logic [ACC_W-1:0]        w_pp;
    logic [ACC_W-1:0]        w_sum;
    logic signed [SH_W-1:0]  w_cat;
    logic signed [SH_W-1:0]  w_shift;
    logic                    w_exc;

    step_counter u_step_counter (
        .clk      (clk),
        .rst_n    (reset),
        .i_clr    (ctrl_MULT),
        .i_en     (w_step),
        .o_wrap_c (w_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start in any state restarts; RUN leaves only on the counter wrap.
    always_comb begin
        w_state_nxt = r_state;
        if (ctrl_MULT) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                RUN:     w_state_nxt = w_wrap ? DONE : RUN;
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        w_step = 1'b0;
        if (r_state == RUN && !ctrl_MULT) begin
            w_step = 1'b1;
        end
    end

    // Booth recode of {b(i+1), b(i), b(i-1)} and accumulate into the upper half.
    always_comb begin
        w_m  = {{2{r_mcand[WIDTH-1]}}, r_mcand};
        w_m2 = {w_m[ACC_W-2:0], 1'b0};
        w_pp = '0;
        case ({r_mult[1:0], r_guard})
            3'b001, 3'b010: w_pp = w_m;
            3'b011:         w_pp = w_m2;
            3'b100:         w_pp = -w_m2;
            3'b101, 3'b110: w_pp = -w_m;
            default:        w_pp = '0;
        endcase
        w_sum   = r_acc + w_pp;
        w_cat   = {w_sum, r_mult, r_guard};
        w_shift = w_cat >>> 2;
        w_exc   = (w_shift[2*WIDTH:WIDTH+1] != {WIDTH{w_shift[WIDTH]}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_mult   <= '0;
            r_guard  <= 1'b0;
            r_mcand  <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy  <= w_wrap;
            r_busy <= (w_state_nxt == RUN);
            if (ctrl_MULT) begin
                r_mcand <= data_operandA;
                r_acc   <= '0;
                r_mult  <= data_operandB;
                r_guard <= 1'b0;
            end else if (w_step) begin
                r_acc   <= w_shift[SH_W-1:WIDTH+1];
                r_mult  <= w_shift[WIDTH:1];
                r_guard <= w_shift[0];
            end
            if (w_wrap) begin
                r_result <= w_shift[WIDTH:1];
                r_exc    <= w_exc;
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Randomized scoreboard bench for mult_booth_seq against a 64-bit arithmetic reference.
module tb_mult_booth_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          start_cyc;
        int          rdy_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t        q[$];
    logic        have_last = 1'b0;
    logic [31:0] last_res = '0;
    logic        last_exc = 1'b0;

    mult_booth_seq #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        logic [63:0] pu;
        p  = longint'($signed(a)) * longint'($signed(b));
        pu = 64'(p);
        e.a   = a;
        e.b   = b;
        e.res = pu[31:0];
        e.exc = (pu[63:32] != {32{pu[31]}});
        e.start_cyc = 0;
        e.rdy_cyc   = 0;
        return e;
    endfunction

    // Called at a negedge: the start is sampled by the next rising edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(a, b);
        e.start_cyc = cyc + 1;
        e.rdy_cyc   = cyc + 17;
        q.delete();
        q.push_back(e);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clk);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            check("wait_done_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    // Monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            logic exp_busy;
            exp_busy = (q.size() > 0) && (cyc >= q[0].start_cyc) && (cyc < q[0].rdy_cyc);
            check("busy", 64'(busy), 64'(exp_busy));
            if (data_resultRDY) begin
                if (q.size() == 0) begin
                    check("spurious_rdy", 64'(data_resultRDY), 64'd0);
                end else begin
                    check("rdy_cycle", 64'(cyc), 64'(q[0].rdy_cyc));
                    check("result", 64'(data_result), 64'(q[0].res));
                    check("exception", 64'(data_exception), 64'(q[0].exc));
                    last_res  = q[0].res;
                    last_exc  = q[0].exc;
                    have_last = 1'b1;
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && cyc >= q[0].rdy_cyc) begin
                check("missing_rdy", 64'(data_resultRDY), 64'd1);
                void'(q.pop_front());
            end else if (q.size() == 0 && have_last) begin
                check("hold_result", 64'(data_result), 64'(last_res));
                check("hold_exception", 64'(data_exception), 64'(last_exc));
            end
        end
    end

    initial begin
        #1;
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exc", 64'(data_exception), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        have_last = 1'b1;
        last_res  = '0;
        last_exc  = 1'b0;
        repeat (3) @(negedge clk);

        start_op(32'd3, 32'd4);                   wait_done();
        start_op(32'hFFFF_FFF9, 32'd6);           wait_done();
        start_op(32'h7FFF_FFFF, 32'd2);           wait_done();
        start_op(32'h8000_0000, 32'hFFFF_FFFF);   wait_done();
        start_op(32'h8000_0000, 32'd1);           wait_done();
        repeat (2) @(negedge clk);

        // Restart mid-run: only the second operation may complete.
        start_op(32'd5, 32'd5);
        repeat (6) @(negedge clk);
        start_op(32'd2, 32'd9);
        wait_done();

        // Asynchronous reset mid-run, then a start on the very first edge after release.
        start_op(32'd1234, 32'd5678);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        last_res = '0;
        last_exc = 1'b0;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_result", 64'(data_result), 64'd0);
        check("midrun_reset_exc", 64'(data_exception), 64'd0);
        check("midrun_reset_rdy", 64'(data_resultRDY), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start_op(32'd1, 32'd1);
        wait_done();

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($signed(16'($urandom))); b = 32'($signed(16'($urandom))); end
                2: begin a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF; b = $urandom; end
                default: begin a = 32'($signed(8'($urandom))); b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000; end
            endcase
            start_op(a, b);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 14)) @(negedge clk);
                start_op($urandom, $urandom);
            end
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
